branch_predictor: RTL

Dynamic branch predictor for the 5-stage MIPS pipeline. It holds a table of 2-bit saturating counters indexed by the fetch PC and drives `prediction1` to fetch. It carries each prediction down to stage 3 as `prediction3`, which the flush logic compares against `aluZero`. At resolution it trains the table and keeps branch/mispredict statistics. It also squashes its own in-flight stage-2/3 entries whenever the pipeline flushes.

---
 rtl/branch_predictor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor
//   Bimodal predictor with 2-bit saturating counters for the 5-stage MIPS pipeline.
//   Each lookup's prediction travels with the branch to stage 3. At resolution,
//   stage 3 trains the table entry that made the prediction and updates the
//   branch and mispredict statistics.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   stall             : hold stage registers, table and statistics
//   flush             : squash in-flight stage-2/3 entries (has priority over stall)
//   pc1, branch1      : fetch PC and stage-1 branch type (01 beq, 11 bne)
//   branch3, aluZero  : stage-3 branch type and ALU zero flag (resolve the outcome)
//   exception         : stage-3 exception; blocks training and statistics
//   prediction1       : combinational taken prediction for the stage-1 instruction
//   prediction3       : prediction carried to stage 3
//   mispredict3       : stage-3 branch resolved against its prediction
//   branch_count      : saturating count of resolved conditional branches
//   mispredict_count  : saturating count of resolved mispredictions
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc1,
    input  logic [1:0]  branch1,
    input  logic [1:0]  branch3,
    input  logic        aluZero,
    input  logic        exception,
    output logic        prediction1,
    output logic        prediction3,
    output logic        mispredict3,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);

    localparam logic [1:0] CTR_INIT = 2'b01;   // weak not-taken

    logic [1:0]       r_table [ENTRIES];
    logic             r_valid2, r_pred2, r_valid3, r_pred3;
    logic [IDX_W-1:0] r_idx2, r_idx3;
    logic [15:0]      r_branch_count, r_mispredict_count;

    logic [IDX_W-1:0] w_idx1;
    logic             w_pred1, w_pred3, w_taken3, w_mispredict3, w_train;

    // Lookup reads the pre-update table: no same-cycle write bypass.
    assign w_idx1  = pc1[IDX_W+1:2];
    assign w_pred1 = branch1[0] & r_table[w_idx1][1];
    assign w_pred3 = r_valid3 & r_pred3;

    always_comb begin
        case (branch3)
            2'b01:   w_taken3 = aluZero;
            2'b11:   w_taken3 = ~aluZero;
            default: w_taken3 = 1'b0;
        endcase
    end

    // A stage-3 entry whose decode disagrees (branch3[0]=0) is ignored.
    assign w_mispredict3 = r_valid3 & branch3[0] & (w_taken3 != w_pred3);
    assign w_train       = r_valid3 & branch3[0] & ~exception & ~stall;

    // Stage registers: flush wins over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid2 <= 1'b0;
            r_pred2  <= 1'b0;
            r_idx2   <= '0;
            r_valid3 <= 1'b0;
            r_pred3  <= 1'b0;
            r_idx3   <= '0;
        end else if (flush) begin
            r_valid2 <= 1'b0;
            r_pred2  <= 1'b0;
            r_idx2   <= '0;
            r_valid3 <= 1'b0;
            r_pred3  <= 1'b0;
            r_idx3   <= '0;
        end else if (!stall) begin
            r_valid2 <= branch1[0];
            r_pred2  <= w_pred1;
            r_idx2   <= w_idx1;
            r_valid3 <= r_valid2;
            r_pred3  <= r_pred2;
            r_idx3   <= r_idx2;
        end
    end

    // Training is not blocked by a same-cycle flush: the resolving branch is older.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) r_table[i] <= CTR_INIT;
        end else if (w_train) begin
            if (w_taken3) begin
                if (r_table[r_idx3] != 2'b11) r_table[r_idx3] <= r_table[r_idx3] + 2'd1;
            end else begin
                if (r_table[r_idx3] != 2'b00) r_table[r_idx3] <= r_table[r_idx3] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_train) begin
            if (r_branch_count != '1) r_branch_count <= r_branch_count + 16'd1;
            if (w_mispredict3 && (r_mispredict_count != '1))
                r_mispredict_count <= r_mispredict_count + 16'd1;
        end
    end

    assign prediction1      = w_pred1;
    assign prediction3      = w_pred3;
    assign mispredict3      = w_mispredict3;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
